// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: coin codes, coin values and the
// change-dispenser state encoding.
package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_5    = 2'b10;
  localparam logic [1:0] COIN_10   = 2'b11;

  localparam logic [4:0] VAL_1  = 5'd1;
  localparam logic [4:0] VAL_5  = 5'd5;
  localparam logic [4:0] VAL_10 = 5'd10;

  localparam logic [4:0] MAX_AMOUNT = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PULSE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } change_state_e;

endpackage

// File: rtl/change_coin_select.sv
// Greedy coin picker: the largest denomination that fits in the amount still
// owed and is still in stock.
module change_coin_select
  import vending_pkg::*;
(
  input  logic [4:0] remaining,
  input  logic [3:0] stock_10,
  input  logic [3:0] stock_5,
  input  logic [3:0] stock_1,
  output logic [1:0] coin,
  output logic [4:0] value,
  output logic       valid
);

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
    coin  = COIN_NONE;
    value = '0;
    valid = 1'b0;
    if (remaining >= VAL_10 && stock_10 != 4'd0) begin
      coin  = COIN_10;
      value = VAL_10;
      valid = 1'b1;
    end else if (remaining >= VAL_5 && stock_5 != 4'd0) begin
      coin  = COIN_5;
      value = VAL_5;
      valid = 1'b1;
    end else if (remaining >= VAL_1 && stock_1 != 4'd0) begin
      coin  = COIN_1;
      value = VAL_1;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change-return FSM: pays an owed amount out as coin pulses, each separated
// by a run of 00 so a downstream edge detector counts every coin once.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int STOCK_10     = 5,
  parameter int STOCK_5      = 5,
  parameter int STOCK_1      = 5,
  parameter int PULSE_CYCLES = 3,
  parameter int GAP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] amount,
  input  logic       refill,
  output logic [1:0] coin_out,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [4:0] remaining,
  output logic [3:0] stock_10,
  output logic [3:0] stock_5,
  output logic [3:0] stock_1
);

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       S10_INIT   = 4'(STOCK_10);
  localparam logic [3:0]       S5_INIT    = 4'(STOCK_5);
  localparam logic [3:0]       S1_INIT    = 4'(STOCK_1);

  change_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       coin_q, coin_d;
  logic [4:0]       remaining_q, remaining_d;
  logic [3:0]       stock_10_q, stock_10_d;
  logic [3:0]       stock_5_q, stock_5_d;
  logic [3:0]       stock_1_q, stock_1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic [1:0] sel_coin;
  logic [4:0] sel_value;
  logic       sel_valid;

  change_coin_select u_select (
    .remaining (remaining_q),
    .stock_10  (stock_10_q),
    .stock_5   (stock_5_q),
    .stock_1   (stock_1_q),
    .coin      (sel_coin),
    .value     (sel_value),
    .valid     (sel_valid)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    coin_d      = coin_q;
    remaining_d = remaining_q;
    stock_10_d  = stock_10_q;
    stock_5_d   = stock_5_q;
    stock_1_d   = stock_1_q;
    error_d     = error_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = amount;
          error_d     = 1'b0;
          state_d     = ST_SELECT;
        end else if (refill) begin
          stock_10_d = S10_INIT;
          stock_5_d  = S5_INIT;
          stock_1_d  = S1_INIT;
        end
      end
      ST_SELECT: begin
        if (sel_valid) begin
          state_d     = ST_PULSE;
          coin_d      = sel_coin;
          cnt_d       = PULSE_LOAD;
          remaining_d = remaining_q - sel_value;
          case (sel_coin)
            COIN_10: stock_10_d = stock_10_q - 4'd1;
            COIN_5:  stock_5_d  = stock_5_q - 4'd1;
            default: stock_1_d  = stock_1_q - 4'd1;
          endcase
        end else begin
          state_d = ST_DONE;
          if (remaining_q != 5'd0) error_d = 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          coin_d  = COIN_NONE;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_SELECT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      coin_q      <= COIN_NONE;
      remaining_q <= '0;
      stock_10_q  <= S10_INIT;
      stock_5_q   <= S5_INIT;
      stock_1_q   <= S1_INIT;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      coin_q      <= coin_d;
      remaining_q <= remaining_d;
      stock_10_q  <= stock_10_d;
      stock_5_q   <= stock_5_d;
      stock_1_q   <= stock_1_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign coin_out  = coin_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign remaining = remaining_q;
  assign stock_10  = stock_10_q;
  assign stock_5   = stock_5_q;
  assign stock_1   = stock_1_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: three stock configurations, directed payouts,
// expected coins and end-of-payout state checked by a monitor from queues.
module tb_change_dispenser;

  typedef struct {
    int         inst;
    logic [1:0] coin;
  } coin_exp_t;

  typedef struct {
    int inst;
    int cyc;
    int err;
    int rem;
    int s10;
    int s5;
    int s1;
  } done_exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       refill = 1'b0;
  logic       start [3];
  logic [4:0] amount [3];
  logic [1:0] coin_out [3];
  logic       busy [3];
  logic       done [3];
  logic       error [3];
  logic [4:0] remaining [3];
  logic [3:0] stock_10 [3];
  logic [3:0] stock_5 [3];
  logic [3:0] stock_1 [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_seen = 0;
  int total [3];
  int hold [3];
  logic [1:0] prev_coin [3];

  coin_exp_t exp_coin_q [$];
  done_exp_t exp_done_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: defaults. Instance 1: no 10-coins. Instance 2: only two 1-coins.
  change_dispenser u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .amount(amount[0]), .refill(refill),
    .coin_out(coin_out[0]), .busy(busy[0]), .done(done[0]), .error(error[0]),
    .remaining(remaining[0]), .stock_10(stock_10[0]), .stock_5(stock_5[0]), .stock_1(stock_1[0])
  );

  change_dispenser #(.STOCK_10(0)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .amount(amount[1]), .refill(refill),
    .coin_out(coin_out[1]), .busy(busy[1]), .done(done[1]), .error(error[1]),
    .remaining(remaining[1]), .stock_10(stock_10[1]), .stock_5(stock_5[1]), .stock_1(stock_1[1])
  );

  change_dispenser #(.STOCK_10(0), .STOCK_5(0), .STOCK_1(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .amount(amount[2]), .refill(refill),
    .coin_out(coin_out[2]), .busy(busy[2]), .done(done[2]), .error(error[2]),
    .remaining(remaining[2]), .stock_10(stock_10[2]), .stock_5(stock_5[2]), .stock_1(stock_1[2])
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int coin_val(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b10:   return 5;
      2'b11:   return 10;
      default: return 0;
    endcase
  endfunction

  // Monitor: acts as the money counter on each coin rising edge and checks done.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        prev_coin[i] = 2'b00;
        hold[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (coin_out[i] != 2'b00) begin
          if (prev_coin[i] == 2'b00) begin
            if (exp_coin_q.size() == 0) begin
              check("unexpected_coin", int'(coin_out[i]), 0);
            end else begin
              coin_exp_t e;
              e = exp_coin_q.pop_front();
              check("coin_instance", i, e.inst);
              check("coin_code", int'(coin_out[i]), int'(e.coin));
            end
            total[i] += coin_val(coin_out[i]);
            hold[i] = 1;
          end else begin
            if (coin_out[i] != prev_coin[i])
              check("coin_change_without_gap", int'(coin_out[i]), int'(prev_coin[i]));
            hold[i]++;
          end
        end else if (prev_coin[i] != 2'b00) begin
          check("pulse_length", hold[i], 3);
        end
        if (done[i]) begin
          if (exp_done_q.size() == 0) begin
            check("unexpected_done", i, -1);
          end else begin
            done_exp_t d;
            d = exp_done_q.pop_front();
            check("done_instance", i, d.inst);
            check("done_cycle", cyc, d.cyc);
            check("error", int'(error[i]), d.err);
            check("remaining", int'(remaining[i]), d.rem);
            check("stock_10", int'(stock_10[i]), d.s10);
            check("stock_5", int'(stock_5[i]), d.s5);
            check("stock_1", int'(stock_1[i]), d.s1);
          end
          done_seen++;
        end
        prev_coin[i] = coin_out[i];
      end
    end
  end

  task automatic push_coin(input int inst, input logic [1:0] c);
    coin_exp_t e;
    e.inst = inst;
    e.coin = c;
    exp_coin_q.push_back(e);
  endtask

  // Start a payout and wait (bounded) for its done pulse; n = coins expected.
  task automatic do_payout(input int inst, input logic [4:0] amt, input int n,
                           input int e_err, input int e_rem,
                           input int e10, input int e5, input int e1);
    done_exp_t d;
    int seen0;
    int budget;
    @(negedge clk);
    amount[inst] = amt;
    start[inst] = 1'b1;
    @(posedge clk);
    #1;
    start[inst] = 1'b0;
    d.inst = inst;
    d.cyc = cyc + 1 + n * 5;
    d.err = e_err;
    d.rem = e_rem;
    d.s10 = e10;
    d.s5 = e5;
    d.s1 = e1;
    exp_done_q.push_back(d);
    seen0 = done_seen;
    budget = 0;
    while (done_seen == seen0 && budget < 200) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (done_seen == seen0) check("done_timeout", 0, 1);
    @(negedge clk);
    check("busy_after_done", int'(busy[inst]), 0);
  endtask

  initial begin
    int budget;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      amount[i] = 5'd0;
      total[i] = 0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    check("rst_coin_out", int'(coin_out[0]), 0);
    check("rst_busy", int'(busy[0]), 0);
    check("rst_done", int'(done[0]), 0);
    check("rst_error", int'(error[0]), 0);
    check("rst_remaining", int'(remaining[0]), 0);
    check("rst_stock_10", int'(stock_10[0]), 5);
    check("rst_stock_5", int'(stock_5[0]), 5);
    check("rst_stock_1", int'(stock_1[0]), 5);
    check("rst_stock_10_inst1", int'(stock_10[1]), 0);

    // No 10-coins: 10 is paid as two 5-coins.
    push_coin(1, 2'b10);
    push_coin(1, 2'b10);
    do_payout(1, 5'd10, 2, 0, 0, 0, 3, 5);

    // Only two 1-coins: 3 owed leaves 1 unpaid and raises error.
    push_coin(2, 2'b01);
    push_coin(2, 2'b01);
    do_payout(2, 5'd3, 2, 1, 1, 0, 0, 0);

    // 16 with defaults; a start(7) and refill arriving mid-payout are ignored.
    push_coin(0, 2'b11);
    push_coin(0, 2'b10);
    push_coin(0, 2'b01);
    fork
      do_payout(0, 5'd16, 3, 0, 0, 4, 4, 4);
      begin
        repeat (7) @(negedge clk);
        amount[0] = 5'd7;
        start[0] = 1'b1;
        refill = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        refill = 1'b0;
      end
    join

    // Zero owed: done two edges after start, no coins, stock untouched.
    do_payout(0, 5'd0, 0, 0, 0, 4, 4, 4);

    @(negedge clk);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    check("refill_stock_10", int'(stock_10[0]), 5);
    check("refill_stock_5", int'(stock_5[0]), 5);
    check("refill_stock_1", int'(stock_1[0]), 5);

    // Maximum amount, looped back into the money-counter model.
    total[0] = 0;
    push_coin(0, 2'b11);
    push_coin(0, 2'b11);
    push_coin(0, 2'b11);
    push_coin(0, 2'b01);
    do_payout(0, 5'd31, 4, 0, 0, 2, 5, 4);
    check("loopback_total", total[0], 31);

    // Exhausts the 10-coins partway through.
    push_coin(0, 2'b11);
    push_coin(0, 2'b11);
    push_coin(0, 2'b10);
    push_coin(0, 2'b01);
    push_coin(0, 2'b01);
    push_coin(0, 2'b01);
    do_payout(0, 5'd28, 6, 0, 0, 0, 4, 1);

    // Runs out of 1-coins: 3 left unpaid.
    push_coin(0, 2'b10);
    push_coin(0, 2'b01);
    do_payout(0, 5'd9, 2, 1, 3, 0, 3, 0);

    // Next accepted start clears the sticky error.
    do_payout(0, 5'd0, 0, 0, 0, 0, 3, 0);

    // Reset while a coin is being driven.
    push_coin(0, 2'b10);
    @(negedge clk);
    amount[0] = 5'd5;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    budget = 0;
    while (coin_out[0] == 2'b00 && budget < 20) begin
      @(negedge clk);
      #1;
      budget++;
    end
    check("coin_before_reset", int'(coin_out[0]), 2);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_coin_out", int'(coin_out[0]), 0);
    check("midrst_busy", int'(busy[0]), 0);
    check("midrst_stock_10", int'(stock_10[0]), 5);
    check("midrst_stock_5", int'(stock_5[0]), 5);
    check("midrst_stock_1", int'(stock_1[0]), 5);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    check("coin_queue_empty", exp_coin_q.size(), 0);
    check("done_queue_empty", exp_done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
